// File: rtl/rr_free_list_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// rr_free_list_pkg : rename-stage sizing and ROB commit port type
// rev 1.0
// ---------------------------------------------------------------
package rr_free_list_pkg;

   localparam int P_REGISTERS = 64;
   localparam int L_REGS      = 8;
   localparam int FL_DEPTH    = P_REGISTERS - L_REGS;
   localparam int FL_CNT_W    = $clog2(FL_DEPTH + 1);

   localparam int PREG_W = $clog2(P_REGISTERS);
   localparam int PTR_W  = $clog2(FL_DEPTH);
   // count_o is one bit wider than the minimum so the subtract never aliases
   localparam int CNT_W  = FL_CNT_W + 1;

   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [PTR_W-1:0]  fl_ptr_t;
   typedef logic [CNT_W-1:0]  fl_cnt_t;

   typedef struct packed {
      logic  valid_commit;
      logic  valid_write;
      logic  flushed;
      preg_t pdst;
      preg_t ppdst;
   } writeback_toARF;

endpackage
`default_nettype wire

// File: rtl/rr_free_list.sv
`default_nettype none
// ---------------------------------------------------------------
// rr_free_list : dual-pop / single-push physical register free list
// rev 1.0
// ---------------------------------------------------------------
module rr_free_list
   import rr_free_list_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           pop_req_i,
   output logic [1:0][PREG_W-1:0] free_preg_o,
   output logic [1:0]           free_valid_o,
   input  writeback_toARF       commit_i,
   output logic [CNT_W-1:0]     count_o,
   output logic                 err_o
);

   preg_t   entry_q [FL_DEPTH];
   preg_t   entry_d [FL_DEPTH];
   fl_ptr_t head_q, head_d;
   fl_ptr_t tail_q, tail_d;
   fl_cnt_t count_q, count_d;
   logic    err_q, err_d;

   logic    [1:0] valid;
   fl_ptr_t head_p1;
   logic    do_pop0, do_pop1, pop_err;
   logic    [1:0] n_pops;
   fl_cnt_t count_post;
   logic    push_req, push_ok;
   preg_t   push_val;

   // FL_DEPTH is not a power of two, so wrap by compare rather than truncation
   function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
      if (p == fl_ptr_t'(FL_DEPTH - 1)) begin
         return '0;
      end
      return p + fl_ptr_t'(1);
   endfunction

   always_comb begin
      valid      = {count_q >= fl_cnt_t'(2), count_q != '0};
      head_p1    = ptr_inc(head_q);
      do_pop0    = pop_req_i[0] & valid[0];
      do_pop1    = (pop_req_i == 2'b11) & valid[1];
      pop_err    = (pop_req_i == 2'b10)
                 | (pop_req_i[0] & ~valid[0])
                 | ((pop_req_i == 2'b11) & ~valid[1]);
      n_pops     = {1'b0, do_pop0} + {1'b0, do_pop1};

      head_d = head_q;
      if (do_pop1) begin
         head_d = ptr_inc(head_p1);
      end else if (do_pop0) begin
         head_d = head_p1;
      end

      // a push sees the list as it is after this cycle's pops
      count_post = count_q - fl_cnt_t'(n_pops);
      push_req   = commit_i.valid_commit & commit_i.valid_write;
      push_ok    = push_req & (count_post != fl_cnt_t'(FL_DEPTH));
      push_val   = commit_i.flushed ? commit_i.pdst : commit_i.ppdst;

      entry_d = entry_q;
      tail_d  = tail_q;
      if (push_ok) begin
         entry_d[tail_q] = push_val;
         tail_d          = ptr_inc(tail_q);
      end

      count_d = count_post + fl_cnt_t'(push_ok);
      err_d   = err_q | pop_err | (push_req & ~push_ok);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            entry_q[i] <= preg_t'(L_REGS + i);
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= fl_cnt_t'(FL_DEPTH);
         err_q   <= 1'b0;
      end else begin
         entry_q <= entry_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign free_preg_o[0] = entry_q[head_q];
   assign free_preg_o[1] = entry_q[head_p1];
   assign free_valid_o   = valid;
   assign count_o        = count_q;
   assign err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_free_list.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_rr_free_list : directed + random checks against a queue model
// rev 1.0
// ---------------------------------------------------------------
module tb_rr_free_list;
   import rr_free_list_pkg::*;

   logic                   clk;
   logic                   rst_n;
   logic [1:0]             pop_req_i;
   logic [1:0][PREG_W-1:0] free_preg_o;
   logic [1:0]             free_valid_o;
   writeback_toARF         commit_i;
   logic [CNT_W-1:0]       count_o;
   logic                   err_o;

   int n_pass  = 0;
   int n_total = 0;

   int fl_q[$];
   bit m_err;

   rr_free_list dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pop_req_i    (pop_req_i),
      .free_preg_o  (free_preg_o),
      .free_valid_o (free_valid_o),
      .commit_i     (commit_i),
      .count_o      (count_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      fl_q.delete();
      for (int i = 0; i < FL_DEPTH; i++) fl_q.push_back(L_REGS + i);
      m_err = 1'b0;
   endtask

   task automatic check_state();
      int sz;
      sz = fl_q.size();
      chk("count", 32'(count_o), 32'(sz));
      chk("valid", 32'(free_valid_o), {30'd0, sz >= 2, sz >= 1});
      chk("err", 32'(err_o), 32'(m_err));
      if (sz >= 1) chk("slot0", 32'(free_preg_o[0]), 32'(fl_q[0]));
      if (sz >= 2) chk("slot1", 32'(free_preg_o[1]), 32'(fl_q[1]));
   endtask

   task automatic idle_inputs();
      pop_req_i = 2'b00;
      commit_i  = '0;
   endtask

   task automatic drive(input logic [1:0] pop, input logic vc, input logic vw,
                        input logic fl, input int pd, input int ppd);
      pop_req_i             = pop;
      commit_i.valid_commit = vc;
      commit_i.valid_write  = vw;
      commit_i.flushed      = fl;
      commit_i.pdst         = preg_t'(pd);
      commit_i.ppdst        = preg_t'(ppd);
      #1;
      check_state();
   endtask

   // apply the free-list rules to the queue, then take the clock edge
   task automatic clock_step();
      int want, got;
      want = (pop_req_i == 2'b01) ? 1 : (pop_req_i == 2'b11) ? 2 : 0;
      if (pop_req_i == 2'b10) m_err = 1'b1;
      got = want;
      if (fl_q.size() < want) begin
         m_err = 1'b1;
         got   = fl_q.size();
      end
      for (int k = 0; k < got; k++) void'(fl_q.pop_front());
      if (commit_i.valid_commit && commit_i.valid_write) begin
         if (fl_q.size() == FL_DEPTH) m_err = 1'b1;
         else fl_q.push_back(commit_i.flushed ? int'(commit_i.pdst) : int'(commit_i.ppdst));
      end
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_inputs();
      model_reset();
   endtask

   task automatic single_pops(input int n);
      for (int k = 0; k < n; k++) begin
         drive(2'b01, 1'b0, 1'b0, 1'b0, 0, 0);
         clock_step();
      end
   endtask

   initial begin
      idle_inputs();
      model_reset();

      // reset state
      do_reset(2);
      #1;
      chk("rst_count", 32'(count_o), 32'd56);
      chk("rst_slot0", 32'(free_preg_o[0]), 32'd8);
      chk("rst_slot1", 32'(free_preg_o[1]), 32'd9);
      chk("rst_valid", 32'(free_valid_o), 32'd3);
      chk("rst_err", 32'(err_o), 32'd0);

      // double pop
      drive(2'b11, 1'b0, 1'b0, 1'b0, 0, 0);
      clock_step();
      chk("dpop_slot0", 32'(free_preg_o[0]), 32'd10);
      chk("dpop_slot1", 32'(free_preg_o[1]), 32'd11);
      chk("dpop_count", 32'(count_o), 32'd54);

      // push into a full list is dropped
      do_reset(1);
      drive(2'b00, 1'b1, 1'b1, 1'b0, 0, 3);
      clock_step();
      chk("ovf_err", 32'(err_o), 32'd1);
      chk("ovf_count", 32'(count_o), 32'd56);

      // ppdst released after a pop
      do_reset(1);
      single_pops(1);
      drive(2'b00, 1'b1, 1'b1, 1'b0, 20, 3);
      clock_step();
      chk("rel_count", 32'(count_o), 32'd56);
      single_pops(55);
      chk("rel_slot0", 32'(free_preg_o[0]), 32'd3);

      // flushed returns pdst
      do_reset(1);
      single_pops(1);
      drive(2'b00, 1'b1, 1'b1, 1'b1, 12, 5);
      clock_step();
      single_pops(55);
      chk("flush_slot0", 32'(free_preg_o[0]), 32'd12);

      // draining past empty
      do_reset(1);
      single_pops(55);
      drive(2'b11, 1'b0, 1'b0, 1'b0, 0, 0);
      clock_step();
      chk("drain_count", 32'(count_o), 32'd0);
      chk("drain_valid", 32'(free_valid_o), 32'd0);
      chk("drain_err", 32'(err_o), 32'd1);
      drive(2'b01, 1'b0, 1'b0, 1'b0, 0, 0);
      clock_step();
      check_state();

      // wrap-around of head+1
      do_reset(1);
      single_pops(55);
      drive(2'b00, 1'b1, 1'b1, 1'b0, 0, 40);
      clock_step();
      drive(2'b00, 1'b1, 1'b1, 1'b0, 0, 41);
      clock_step();
      drive(2'b11, 1'b0, 1'b0, 1'b0, 0, 0);
      chk("wrap_slot0", 32'(free_preg_o[0]), 32'd63);
      chk("wrap_slot1", 32'(free_preg_o[1]), 32'd40);
      clock_step();
      check_state();

      // pop and push together on a full list
      do_reset(1);
      drive(2'b11, 1'b1, 1'b1, 1'b0, 0, 7);
      clock_step();
      chk("sim_count", 32'(count_o), 32'd55);
      chk("sim_err", 32'(err_o), 32'd0);

      // random traffic with periodic mid-stream resets
      for (int blk = 0; blk < 4; blk++) begin
         for (int it = 0; it < 120; it++) begin
            int r;
            logic [1:0] pop;
            logic vc, vw;
            r   = int'($urandom_range(0, 99));
            pop = (r < 3) ? 2'b10 : (it < 60) ? ((r < 55) ? 2'b11 : (r < 85) ? 2'b01 : 2'b00)
                                              : ((r < 15) ? 2'b11 : (r < 35) ? 2'b01 : 2'b00);
            vc  = ($urandom_range(0, 99) < ((it < 60) ? 30 : 85));
            vw  = ($urandom_range(0, 9) != 0);
            drive(pop, vc, vw, 1'(($urandom) & 1), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 63)));
            clock_step();
         end
         check_state();
         pop_req_i = 2'b11;
         do_reset(1);
         #1;
         check_state();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
